jpeg_bitpack: RTL and testbench

- Entropy-coder output stage of the JPEG encoder; the write-side counterpart of the decoder's bitstream reader.
- Accepts right-justified variable-length codes (Huffman code plus appended magnitude bits) and packs them MSB-first into bytes.
- Inserts a stuffed 0x00 after every 0xFF data byte, as JPEG requires.
- On flush, pads the final partial byte with 1s and appends the EOI marker 0xFF 0xD9.

---
 rtl/jpeg_bitpack_if.sv | 31 +++
 rtl/jpeg_bitpack.sv | 158 +++++++++++++++
 tb/tb_jpeg_bitpack.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_bitpack_if.sv
// jpeg_bitpack_if: handshake bundle between the entropy coder, the bit
// packer and the byte sink.
//   code_in/code_len/code_we/code_rdy : right-justified variable-length codes in
//   flush                             : end-of-image request (single-cycle pulse)
//   dout/dout_we/dout_rdy             : packed, stuffed output byte stream
//   done                              : pulse after the EOI marker has left
// master = upstream coder + downstream sink (the bench), slave = the packer.
interface jpeg_bitpack_if #(
  parameter int CODE_W = 32,
  parameter int LEN_W  = 6
);
  logic [CODE_W-1:0] code_in;
  logic [LEN_W-1:0]  code_len;
  logic              code_we;
  logic              code_rdy;
  logic              flush;
  logic [7:0]        dout;
  logic              dout_we;
  logic              dout_rdy;
  logic              done;

  modport master (
    output code_in, code_len, code_we, flush, dout_rdy,
    input  code_rdy, dout, dout_we, done
  );

  modport slave (
    input  code_in, code_len, code_we, flush, dout_rdy,
    output code_rdy, dout, dout_we, done
  );
endinterface

// File: rtl/jpeg_bitpack.sv
// jpeg_bitpack: JPEG entropy-coder output stage. Packs right-justified
// variable-length codes MSB-first into bytes, inserts a 0x00 after every 0xFF
// data byte, and on flush pads the last partial byte with ones and appends the
// EOI marker 0xFF 0xD9.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : jpeg_bitpack_if slave (code input, flush, byte output, done)
module jpeg_bitpack #(
  parameter int CODE_W = 32,
  parameter int LEN_W  = 6
) (
  input  logic          clk,
  input  logic          rst,
  jpeg_bitpack_if.slave bus
);

  typedef enum logic [2:0] {
    S_RUN, S_PAD, S_DRAIN, S_EOI_FF, S_EOI_D9, S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [63:0] acc, acc_nx, merged;
  logic [6:0]  fill, fill_nx, fill_sum, len7;
  logic        stf, stf_nx, flush_pend, flush_pend_nx;
  logic [7:0]  dout_i;
  logic        dout_we_i, code_rdy_i, accept, emit, data_phase;
  logic [3:0]  pad_bytes;

  // Mask the code to len bits and place it just below the fill point.
  function automatic logic [63:0] align_code(input logic [CODE_W-1:0] code,
                                             input logic [6:0] len,
                                             input logic [6:0] fl);
    logic [63:0] m;
    m = 64'(code);
    if (len < 7'(CODE_W)) m = m & ((64'd1 << len) - 64'd1);
    if (len == 7'd0) return 64'd0;
    return m << (7'd64 - fl - len);
  endfunction

  // Ones from the fill point down to the next byte boundary.
  function automatic logic [63:0] pad_ones(input logic [6:0] fl);
    logic [3:0] n;
    n = 4'd8 - {1'b0, fl[2:0]};
    if (fl[2:0] == 3'd0) return 64'd0;
    return ((64'd1 << n) - 64'd1) << (7'd64 - fl - 7'(n));
  endfunction

  assign len7       = 7'(bus.code_len);
  assign data_phase = (state == S_RUN) || (state == S_PAD) || (state == S_DRAIN);
  assign code_rdy_i = (state == S_RUN) && (fill <= 7'd32) && !flush_pend;
  assign accept     = bus.code_we & code_rdy_i;
  assign emit       = dout_we_i & bus.dout_rdy;
  assign pad_bytes  = fill[6:3] + 4'(|fill[2:0]);

  assign bus.code_rdy = code_rdy_i;
  assign bus.dout     = dout_i;
  assign bus.dout_we  = dout_we_i;
  assign bus.done     = (state == S_DONE);

  // Output byte is a pure function of registered state, so it holds while stalled.
  always_comb begin
    dout_i    = 8'h00;
    dout_we_i = 1'b0;
    case (state)
      S_RUN, S_PAD, S_DRAIN: begin
        if (stf) begin
          dout_we_i = 1'b1;
        end else if (fill >= 7'd8) begin
          dout_i    = acc[63:56];
          dout_we_i = 1'b1;
        end
      end
      S_EOI_FF: begin
        dout_i    = 8'hFF;
        dout_we_i = 1'b1;
      end
      S_EOI_D9: begin
        dout_i    = 8'hD9;
        dout_we_i = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx      = state;
    acc_nx        = acc;
    fill_nx       = fill;
    stf_nx        = stf;
    flush_pend_nx = flush_pend;
    merged        = acc;
    fill_sum      = fill;

    case (state)
      S_RUN: begin
        if (accept) begin
          merged   = acc | align_code(bus.code_in, len7, fill);
          fill_sum = fill + len7;
        end
        // A code arriving with the flush pulse is merged before the flush takes effect.
        if (flush_pend) begin
          state_nx      = S_PAD;
          flush_pend_nx = 1'b0;
        end else if (bus.flush) begin
          flush_pend_nx = 1'b1;
        end
      end
      S_PAD: begin
        merged   = acc | pad_ones(fill);
        fill_sum = {pad_bytes, 3'b000};
        state_nx = S_DRAIN;
      end
      S_DRAIN:  if (fill == 7'd0 && !stf) state_nx = S_EOI_FF;
      S_EOI_FF: if (emit) state_nx = S_EOI_D9;
      S_EOI_D9: if (emit) state_nx = S_DONE;
      S_DONE:   state_nx = S_RUN;
      default:  state_nx = S_RUN;
    endcase

    // Accept/pad and byte emit can coincide: merge first, then shift out the top byte.
    if (data_phase) begin
      if (emit && stf) begin
        stf_nx  = 1'b0;
        acc_nx  = merged;
        fill_nx = fill_sum;
      end else if (emit) begin
        acc_nx  = merged << 8;
        fill_nx = fill_sum - 7'd8;
        stf_nx  = (acc[63:56] == 8'hFF);
      end else begin
        acc_nx  = merged;
        fill_nx = fill_sum;
      end
    end else if (state == S_DONE) begin
      acc_nx  = 64'd0;
      fill_nx = 7'd0;
      stf_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_RUN;
      acc        <= 64'd0;
      fill       <= 7'd0;
      stf        <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nx;
      acc        <= acc_nx;
      fill       <= fill_nx;
      stf        <= stf_nx;
      flush_pend <= flush_pend_nx;
    end
  end

endmodule

// File: tb/tb_jpeg_bitpack.sv
// tb_jpeg_bitpack: self-checking bench for jpeg_bitpack. Table-driven single-code
// flush vectors, hand-written multi-cycle corner cases, and randomized code
// streams checked against a bit-queue reference packer.
module tb_jpeg_bitpack;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jpeg_bitpack_if #(.CODE_W(32), .LEN_W(6)) bus();
  jpeg_bitpack #(.CODE_W(32), .LEN_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int dones    = 0;
  bit prev_d9  = 1'b0;
  bit rand_rdy = 1'b0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         mbits[$];

  typedef struct {
    logic [31:0] code;
    int          len;
    int          n;
    logic [47:0] b;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Byte monitor: record every accepted byte; done must follow an accepted 0xD9.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.done) begin
        dones++;
        check("done_after_d9", 32'(prev_d9), 32'd1);
      end
      prev_d9 = 1'b0;
      if (bus.dout_we && bus.dout_rdy) begin
        got_q.push_back(bus.dout);
        prev_d9 = (bus.dout == 8'hD9);
      end
    end else begin
      prev_d9 = 1'b0;
    end
  end

  // Reference packer: a plain queue of bits, bytes cut off 8 at a time.
  task automatic m_bytes();
    logic [7:0] b;
    while (mbits.size() >= 8) begin
      b = 8'h00;
      for (int i = 0; i < 8; i++) b = {b[6:0], mbits.pop_front()};
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endtask

  task automatic m_push(input logic [31:0] code, input int len);
    for (int i = len - 1; i >= 0; i--) mbits.push_back(code[i]);
    m_bytes();
  endtask

  task automatic m_flush();
    while (mbits.size() % 8 != 0) mbits.push_back(1'b1);
    m_bytes();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.dout_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] code, input int len);
    bit ok = 1'b0;
    bus.code_in  = code;
    bus.code_len = 6'(len);
    bus.code_we  = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (bus.code_rdy) begin
        m_push(code, len);
        ok = 1'b1;
      end
      tick();
    end
    bus.code_we = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic flush_pulse();
    bus.flush = 1'b1;
    @(negedge clk);
    m_flush();
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start = dones;
    bit got   = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (dones > start) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    @(negedge clk);
    check({name, "_done_single"}, 32'(bus.done), 32'd0);
    check({name, "_rdy_after"}, 32'(bus.code_rdy), 32'd1);
    tick();
  endtask

  task automatic compare_stream(input string name);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    mbits.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] c[6];
    int acc_bits;

    tbl[0] = '{32'h0000_0005,  3, 3, 48'hBF_FF_D9_00_00_00};
    tbl[1] = '{32'h0000_007F,  7, 4, 48'hFF_00_FF_D9_00_00};
    tbl[2] = '{32'h0000_005A,  8, 3, 48'h5A_FF_D9_00_00_00};
    tbl[3] = '{32'h0000_FF12, 16, 5, 48'hFF_00_12_FF_D9_00};
    tbl[4] = '{32'hFFFF_FFFF,  0, 2, 48'hFF_D9_00_00_00_00};
    tbl[5] = '{32'hDEAD_BEEF, 32, 6, 48'hDE_AD_BE_EF_FF_D9};
    tbl[6] = '{32'hFFFF_FFFF,  4, 4, 48'hFF_00_FF_D9_00_00};
    tbl[7] = '{32'hFFFF_FABC, 12, 4, 48'hAB_CF_FF_D9_00_00};

    bus.code_in  = '0;
    bus.code_len = '0;
    bus.code_we  = 1'b0;
    bus.flush    = 1'b0;
    bus.dout_rdy = 1'b1;

    // Reset state
    rst = 1'b1;
    #1 rst = 1'b0;
    #3;
    check("rst_dout", 32'(bus.dout), 32'h00);
    check("rst_dout_we", 32'(bus.dout_we), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_code_rdy", 32'(bus.code_rdy), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // 101 + 10011 -> 0xB3 for exactly one cycle
    send(32'h5, 3);
    send(32'h13, 5);
    @(negedge clk);
    check("b3_we", 32'(bus.dout_we), 32'd1);
    check("b3_dout", 32'(bus.dout), 32'hB3);
    tick();
    @(negedge clk);
    check("b3_we_after", 32'(bus.dout_we), 32'd0);
    tick();
    compare_stream("b3");

    // 0xFF12 -> FF, 00, 12 on consecutive cycles
    send(32'hFF12, 16);
    @(negedge clk);
    check("ff12_b0", {23'd0, bus.dout_we, bus.dout}, 32'h1FF);
    tick();
    @(negedge clk);
    check("ff12_b1", {23'd0, bus.dout_we, bus.dout}, 32'h100);
    tick();
    @(negedge clk);
    check("ff12_b2", {23'd0, bus.dout_we, bus.dout}, 32'h112);
    tick();
    @(negedge clk);
    check("ff12_idle", 32'(bus.dout_we), 32'd0);
    tick();
    compare_stream("ff12");

    // Table: one code, flush, full byte stream including EOI
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].code, tbl[i].len);
      flush_pulse();
      wait_done($sformatf("tbl%0d", i));
      exp_q.delete();
      for (int j = 0; j < tbl[i].n; j++) exp_q.push_back(tbl[i].b[47 - 8*j -: 8]);
      compare_stream($sformatf("tbl%0d", i));
    end

    // Code and flush in the same cycle
    bus.code_in  = 32'h5;
    bus.code_len = 6'd3;
    bus.code_we  = 1'b1;
    bus.flush    = 1'b1;
    @(negedge clk);
    check("cflush_rdy", 32'(bus.code_rdy), 32'd1);
    m_push(32'h5, 3);
    m_flush();
    tick();
    bus.code_we = 1'b0;
    bus.flush   = 1'b0;
    wait_done("cflush");
    compare_stream("cflush");

    // Output stall with 32-bit codes offered every cycle
    bus.dout_rdy = 1'b0;
    acc_bits = 0;
    for (int i = 0; i < 6; i++) c[i] = $urandom;
    for (int i = 0; i < 6; i++) begin
      bus.code_in  = c[i];
      bus.code_len = 6'd32;
      bus.code_we  = 1'b1;
      @(negedge clk);
      check($sformatf("stall_rdy%0d", i), 32'(bus.code_rdy), 32'(acc_bits <= 32));
      if (i >= 1) begin
        check($sformatf("stall_we%0d", i), 32'(bus.dout_we), 32'd1);
        check($sformatf("stall_dout%0d", i), 32'(bus.dout), 32'(c[0][31:24]));
      end
      if (acc_bits <= 32) begin
        m_push(c[i], 32);
        acc_bits += 32;
      end
      tick();
    end
    bus.code_we  = 1'b0;
    bus.dout_rdy = 1'b1;
    flush_pulse();
    wait_done("stall");
    compare_stream("stall");

    // Reset while a stuff byte is pending
    send(32'hFF, 8);
    @(negedge clk);
    check("rs_ff", 32'(bus.dout), 32'hFF);
    tick();
    @(negedge clk);
    check("rs_stuff", {23'd0, bus.dout_we, bus.dout}, 32'h100);
    #1 rst = 1'b0;
    #1;
    check("rs_we_now", 32'(bus.dout_we), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    got_q.delete();
    exp_q.delete();
    mbits.delete();
    tick();
    send(32'h5A, 8);
    repeat (5) tick();
    compare_stream("rs_5a");

    // Randomized code streams with random back-pressure
    for (int r = 0; r < 3; r++) begin
      rand_rdy = 1'b1;
      for (int k = 0; k < 40; k++) send($urandom, int'($urandom_range(0, 32)));
      flush_pulse();
      wait_done($sformatf("rand%0d", r));
      rand_rdy     = 1'b0;
      bus.dout_rdy = 1'b1;
      compare_stream($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
